// File: rtl/paint_ctrl_pkg.sv
// paint_ctrl_pkg.sv - State codes, mouse command encodings and tool-width helper for paint_control_fsm
package paint_ctrl_pkg;

    // 4-bit state codes; 11..15 are unused and recover to CLEAR.
    typedef enum logic [3:0] {
        S_IDLE          = 4'd0,
        S_MOVE          = 4'd1,
        S_WAIT          = 4'd2,
        S_CLEAN         = 4'd3,
        S_DRAW          = 4'd4,
        S_ERASE         = 4'd5,
        S_CLEAR_WAIT    = 4'd6,
        S_CLEAR         = 4'd7,
        S_RESET_MOUSE   = 4'd8,
        S_TX_WAIT       = 4'd9,
        S_DISABLE_MOUSE = 4'd10
    } state_t;

    // Payload carried on oEnableMouse with each host-to-mouse command.
    localparam logic CMD_MOUSE_ENABLE  = 1'b1;
    localparam logic CMD_MOUSE_DISABLE = 1'b0;

    // Tool index width: max(1, clog2(num_tools)).
    function automatic int tool_w(input int num_tools);
        return (num_tools <= 2) ? 1 : $clog2(num_tools);
    endfunction

endpackage

// File: rtl/ctrl_cycle_counter.sv
// ctrl_cycle_counter.sv - Cycle counter with sync clear, enable and terminal-compare flag
//  Ports: iClk, iResetn (sync active-low), clr (zero next cycle), en (count up),
//         term (compare value), hit (count == term).
module ctrl_cycle_counter #(
    parameter int CNT_W = 21
) (
    input  logic             iClk,
    input  logic             iResetn,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             hit
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge iClk) begin
        if (!iResetn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign hit = (count == term);

endmodule

// File: rtl/paint_control_fsm.sv
// paint_control_fsm.sv - Mouse paint pipeline control FSM (move/draw/erase/clear, tool latch, pacing, watchdog, mouse cmds)
//  Inputs : iClk, iResetn (sync active-low), iBtnL, iBtnR, iMove, iClear, iDone, iToolSel, iTxAck
//  Outputs: oState (state code), oTool (latched tool), oEnableMouse (command payload),
//           oStartTransmission (1-cycle command start), oTimeout (sticky watchdog flag)
//  Build option: CLEAR_MOUSE_DISABLE_EN - disable the mouse for the duration of a clear.
module paint_control_fsm
    import paint_ctrl_pkg::*;
#(
    parameter int NUM_TOOLS         = 4,
    parameter int TOOL_W            = tool_w(NUM_TOOLS),
    parameter int ANIM_DELAY_CYCLES = 16,
    parameter int DONE_TIMEOUT      = 2**20,
    parameter int CNT_W             = 21
) (
    input  logic              iClk,
    input  logic              iResetn,
    input  logic              iBtnL,
    input  logic              iBtnR,
    input  logic              iMove,
    input  logic              iClear,
    input  logic              iDone,
    input  logic [TOOL_W-1:0] iToolSel,
    input  logic              iTxAck,
    output logic [3:0]        oState,
    output logic [TOOL_W-1:0] oTool,
    output logic              oEnableMouse,
    output logic              oStartTransmission,
    output logic              oTimeout
);

    localparam int               WAIT_CYCLES = (ANIM_DELAY_CYCLES < 1) ? 1 : ANIM_DELAY_CYCLES;
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WD_LAST     = CNT_W'((DONE_TIMEOUT > 0) ? DONE_TIMEOUT - 1 : 0);
    localparam bit               WD_EN       = (DONE_TIMEOUT > 0);
    localparam logic [TOOL_W:0]  TOOL_LIMIT  = (TOOL_W + 1)'(NUM_TOOLS);

    state_t           state;
    state_t           state_next;
    logic             init_pend;
    logic             tx_from_disable;   // TX_WAIT returns to CLEAR instead of IDLE
    logic             guarded;
    logic             cnt_en;
    logic             cnt_hit;
    logic             wd_fire;
    logic [CNT_W-1:0] cnt_term;

    // One counter serves both the WAIT pacing and the datapath watchdog,
    // since the two never run in the same state.
    assign cnt_term = (state == S_WAIT) ? WAIT_LAST : WD_LAST;

    ctrl_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .iClk    (iClk),
        .iResetn (iResetn),
        .clr     (state_next != state),
        .en      (cnt_en),
        .term    (cnt_term),
        .hit     (cnt_hit)
    );

    always_comb begin
        guarded    = (state == S_MOVE) || (state == S_CLEAN) || (state == S_DRAW) ||
                     (state == S_ERASE) || (state == S_CLEAR);
        cnt_en     = guarded || (state == S_WAIT);
        // A completion arriving on the terminal cycle wins over the watchdog.
        wd_fire    = WD_EN && guarded && !iDone && cnt_hit;
        state_next = state;
        if (wd_fire) begin
            state_next = S_RESET_MOUSE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iMove)       state_next = S_MOVE;
                    else if (iBtnL)  state_next = S_DRAW;
                    else if (iBtnR)  state_next = S_ERASE;
                    else if (iClear) state_next = S_CLEAR_WAIT;
                end
                S_MOVE:  if (iDone)   state_next = S_WAIT;
                S_WAIT:  if (cnt_hit) state_next = S_CLEAN;
                S_CLEAN, S_DRAW, S_ERASE: if (iDone) state_next = S_IDLE;
                S_CLEAR_WAIT: begin
                    if (!iClear) begin
`ifdef CLEAR_MOUSE_DISABLE_EN
                        state_next = S_DISABLE_MOUSE;
`else
                        state_next = S_CLEAR;
`endif
                    end
                end
                S_CLEAR: begin
                    if (iDone) begin
                        state_next = (init_pend || oEnableMouse == CMD_MOUSE_DISABLE) ?
                                     S_RESET_MOUSE : S_IDLE;
                    end
                end
                S_RESET_MOUSE: state_next = S_TX_WAIT;
                S_TX_WAIT: begin
                    if (iTxAck) state_next = tx_from_disable ? S_CLEAR : S_IDLE;
                end
`ifdef CLEAR_MOUSE_DISABLE_EN
                S_DISABLE_MOUSE: state_next = S_TX_WAIT;
`endif
                default: state_next = S_CLEAR;
            endcase
        end
    end

    // Outputs are registered off state_next so they line up with the state
    // they belong to (e.g. the TX pulse is high exactly while in RESET_MOUSE).
    always_ff @(posedge iClk) begin
        if (!iResetn) begin
            state              <= S_CLEAR;
            oTool              <= '0;
            oEnableMouse       <= CMD_MOUSE_ENABLE;
            oStartTransmission <= 1'b0;
            oTimeout           <= 1'b0;
            init_pend          <= 1'b1;
            tx_from_disable    <= 1'b0;
        end else begin
            state              <= state_next;
            oStartTransmission <= (state_next == S_RESET_MOUSE) || (state_next == S_DISABLE_MOUSE);
            if (state_next == S_RESET_MOUSE) begin
                oEnableMouse    <= CMD_MOUSE_ENABLE;
                init_pend       <= 1'b0;
                tx_from_disable <= 1'b0;
            end
            if (state_next == S_DISABLE_MOUSE) begin
                oEnableMouse    <= CMD_MOUSE_DISABLE;
                tx_from_disable <= 1'b1;
            end
            if (wd_fire) begin
                oTimeout <= 1'b1;
            end
            // Out-of-range tool requests keep the previous tool.
            if (state == S_IDLE && state_next == S_DRAW && {1'b0, iToolSel} < TOOL_LIMIT) begin
                oTool <= iToolSel;
            end
        end
    end

    assign oState = state;

endmodule
